scroll_draw_scheduler: RTL and testbench



---
 rtl/scroll_draw_scheduler_pkg.sv | 23 ++
 rtl/scroll_draw_scheduler_raster.sv | 46 ++++
 rtl/scroll_draw_scheduler.sv | 164 ++++++++++++++++
 tb/tb_scroll_draw_scheduler.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/scroll_draw_scheduler_pkg.sv
// draw_pkg: shared types and constants for the scroll/draw scheduler.
//   draw_state_t : frame sequencer states (IDLE, BG, SPR, FIN)
//   H_RES_DEF / V_RES_DEF : default 160x120 screen size
//   COLOUR_W     : adapter colour width
//   cnt_w/addr_w : counter and ROM address width helpers
package draw_pkg;

  typedef enum logic [1:0] {IDLE, BG, SPR, FIN} draw_state_t;

  localparam int H_RES_DEF = 160;
  localparam int V_RES_DEF = 120;
  localparam int COLOUR_W  = 3;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Sprite ROM address is {sy, sx}; both extents are powers of two.
  function automatic int addr_w(input int w, input int h);
    return cnt_w(w) + cnt_w(h);
  endfunction

endpackage

// File: rtl/scroll_draw_scheduler_raster.sv
// raster_counter: enabled x/y scan counter over a W x H raster.
// x runs 0..W-1 and then y advances; the whole scan wraps to (0,0) after
// the last position. last is high while the counter sits on (W-1, H-1).
//   Clock, Resetn : clock, synchronous active-low reset
//   en            : advance one position this cycle
//   x, y          : current scan position
//   last          : current position is the final one of the raster
module raster_counter
  import draw_pkg::*;
#(
  parameter int W = 16,
  parameter int H = 16
) (
  input  logic                Clock,
  input  logic                Resetn,
  input  logic                en,
  output logic [cnt_w(W)-1:0] x,
  output logic [cnt_w(H)-1:0] y,
  output logic                last
);

  localparam int XW = cnt_w(W);
  localparam int YW = cnt_w(H);

  logic x_end;
  logic y_end;

  assign x_end = (x == XW'(W - 1));
  assign y_end = (y == YW'(H - 1));
  assign last  = x_end && y_end;

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      x <= '0;
      y <= '0;
    end else if (en) begin
      if (x_end) begin
        x <= '0;
        y <= y_end ? '0 : y + YW'(1);
      end else begin
        x <= x + XW'(1);
      end
    end
  end

endmodule

// File: rtl/scroll_draw_scheduler.sv
// scroll_draw_scheduler: frame sequencer for the VGA plotting path.
// Each Tick advances the vertical scroll Offset and issues one full redraw:
// the shifted background, then the car sprite. This block is the only
// driver of the adapter's plot port.
//   Clock, Resetn      : clock, synchronous active-low reset
//   Tick               : redraw request (one deep pending if busy)
//   SprX, SprY         : sprite top-left, latched at frame start
//   BgAddr/BgColour    : background ROM (data one cycle after address)
//   SprAddr/SprColour  : sprite ROM (data one cycle after address)
//   VGA_X/VGA_Y/VGA_COLOUR/plot : adapter pixel write
//   Busy, Done, Offset : frame in progress, last-pixel pulse, scroll offset
// Build option: SPRITE_TRANSPARENCY_EN suppresses sprite pixels whose colour
// equals TRANS_COLOUR.
module scroll_draw_scheduler
  import draw_pkg::*;
#(
  parameter int H_RES = H_RES_DEF,
  parameter int V_RES = V_RES_DEF,
  parameter int SPR_W = 16,
  parameter int SPR_H = 16,
  parameter logic [COLOUR_W-1:0] TRANS_COLOUR = 3'b000
) (
  input  logic                            Clock,
  input  logic                            Resetn,
  input  logic                            Tick,
  input  logic [7:0]                      SprX,
  input  logic [6:0]                      SprY,
  output logic [14:0]                     BgAddr,
  input  logic [COLOUR_W-1:0]             BgColour,
  output logic [addr_w(SPR_W,SPR_H)-1:0]  SprAddr,
  input  logic [COLOUR_W-1:0]             SprColour,
  output logic [7:0]                      VGA_X,
  output logic [6:0]                      VGA_Y,
  output logic [COLOUR_W-1:0]             VGA_COLOUR,
  output logic                            plot,
  output logic                            Busy,
  output logic                            Done,
  output logic [6:0]                      Offset
);

  localparam int CW  = cnt_w(H_RES);
  localparam int RW  = cnt_w(V_RES);
  localparam int SXW = cnt_w(SPR_W);
  localparam int SYW = cnt_w(SPR_H);
`ifdef SPRITE_TRANSPARENCY_EN
  localparam bit TRANS_EN = 1'b1;
`else
  localparam bit TRANS_EN = 1'b0;
`endif

  draw_state_t state_q, state_d;
  logic start;

  logic [6:0] offset_q;
  logic       pending_q;
  logic [7:0] spr_x_q;
  logic [6:0] spr_y_q;

  logic [CW-1:0]  col;
  logic [RW-1:0]  row;
  logic           bg_last;
  logic [SXW-1:0] sx;
  logic [SYW-1:0] sy;
  logic           spr_last;

  logic [7:0] row_diff;
  logic [6:0] src_row;
  logic [8:0] pix_x;
  logic [7:0] pix_y;
  logic       spr_in;

  logic       plot_q;
  logic       spr_phase_q;
  logic [7:0] x_q;
  logic [6:0] y_q;
  logic       trans_hit;

  raster_counter #(.W(H_RES), .H(V_RES)) u_bg_scan (
    .Clock (Clock),
    .Resetn(Resetn),
    .en    (state_q == BG),
    .x     (col),
    .y     (row),
    .last  (bg_last)
  );

  raster_counter #(.W(SPR_W), .H(SPR_H)) u_spr_scan (
    .Clock (Clock),
    .Resetn(Resetn),
    .en    (state_q == SPR),
    .x     (sx),
    .y     (sy),
    .last  (spr_last)
  );

  // Scrolling: screen row r shows ROM row (r - Offset) mod V_RES.
  assign row_diff = 8'(row) - {1'b0, offset_q};
  assign src_row  = row_diff[7] ? 7'(row_diff + 8'(V_RES)) : row_diff[6:0];
  assign BgAddr   = {src_row, 8'(col)};
  assign SprAddr  = {sy, sx};

  // Wide sums so off-screen sprite pixels are clipped, never wrapped.
  assign pix_x  = {1'b0, spr_x_q} + 9'(sx);
  assign pix_y  = {1'b0, spr_y_q} + 8'(sy);
  assign spr_in = (pix_x < 9'(H_RES)) && (pix_y < 8'(V_RES));

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    case (state_q)
      IDLE: begin
        if (Tick || pending_q) begin
          state_d = BG;
          start   = 1'b1;
        end
      end
      BG:      if (bg_last)  state_d = SPR;
      SPR:     if (spr_last) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q     <= IDLE;
      offset_q    <= '0;
      pending_q   <= 1'b0;
      spr_x_q     <= '0;
      spr_y_q     <= '0;
      plot_q      <= 1'b0;
      spr_phase_q <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        offset_q <= (offset_q == 7'(V_RES - 1)) ? '0 : offset_q + 7'd1;
        spr_x_q  <= SprX;
        spr_y_q  <= SprY;
      end
      if (start)
        pending_q <= 1'b0;
      else if (Tick && (state_q != IDLE))
        pending_q <= 1'b1;
      plot_q      <= (state_q == BG) || ((state_q == SPR) && spr_in);
      spr_phase_q <= (state_q == SPR);
      x_q         <= (state_q == SPR) ? pix_x[7:0] : 8'(col);
      y_q         <= (state_q == SPR) ? pix_y[6:0] : 7'(row);
    end
  end

  // ROM data arrives in the same cycle as the registered coordinates, so
  // colour and the transparency test are taken straight from the ROM port.
  assign trans_hit  = TRANS_EN && spr_phase_q && (SprColour == TRANS_COLOUR);
  assign plot       = plot_q && !trans_hit;
  assign VGA_COLOUR = !plot_q ? '0 : (spr_phase_q ? SprColour : BgColour);
  assign VGA_X      = x_q;
  assign VGA_Y      = y_q;
  assign Busy       = (state_q != IDLE);
  assign Done       = (state_q == FIN);
  assign Offset     = offset_q;

endmodule

// File: tb/tb_scroll_draw_scheduler.sv
module tb_scroll_draw_scheduler;

  logic        Clock = 1'b0;
  logic        Resetn;
  logic        Tick;
  logic [7:0]  SprX;
  logic [6:0]  SprY;
  logic [14:0] BgAddr;
  logic [2:0]  BgColour;
  logic [7:0]  SprAddr;
  logic [2:0]  SprColour;
  logic [7:0]  VGA_X;
  logic [6:0]  VGA_Y;
  logic [2:0]  VGA_COLOUR;
  logic        plot, Busy, Done;
  logic [6:0]  Offset;

  // Small-raster instance (4x5 screen, 2x2 sprite) for the offset wrap.
  logic        s_tick;
  logic [14:0] s_bg_addr;
  logic [1:0]  s_spr_addr;
  logic [7:0]  s_vga_x;
  logic [6:0]  s_vga_y;
  logic [2:0]  s_vga_colour;
  logic        s_plot, s_busy, s_done;
  logic [6:0]  s_offset;

  logic [2:0] spr_mem [256];

  int n_checks = 0;
  int n_fail   = 0;

`ifdef SPRITE_TRANSPARENCY_EN
  localparam int EXP_SPR_F1 = 1;
  localparam int EXP_SPR_F2 = 1;
`else
  localparam int EXP_SPR_F1 = 256;
  localparam int EXP_SPR_F2 = 100;
`endif

  always #5 Clock = ~Clock;

  scroll_draw_scheduler dut (
    .Clock(Clock), .Resetn(Resetn), .Tick(Tick), .SprX(SprX), .SprY(SprY),
    .BgAddr(BgAddr), .BgColour(BgColour), .SprAddr(SprAddr), .SprColour(SprColour),
    .VGA_X(VGA_X), .VGA_Y(VGA_Y), .VGA_COLOUR(VGA_COLOUR), .plot(plot),
    .Busy(Busy), .Done(Done), .Offset(Offset)
  );

  scroll_draw_scheduler #(.H_RES(4), .V_RES(5), .SPR_W(2), .SPR_H(2)) dut_small (
    .Clock(Clock), .Resetn(Resetn), .Tick(s_tick), .SprX(8'd1), .SprY(7'd1),
    .BgAddr(s_bg_addr), .BgColour(3'd0), .SprAddr(s_spr_addr), .SprColour(3'd0),
    .VGA_X(s_vga_x), .VGA_Y(s_vga_y), .VGA_COLOUR(s_vga_colour), .plot(s_plot),
    .Busy(s_busy), .Done(s_done), .Offset(s_offset)
  );

  function automatic logic [2:0] bg_fn(input logic [14:0] a);
    return a[2:0] ^ a[10:8];
  endfunction

  // Synchronous ROM models.
  always_ff @(posedge Clock) begin
    BgColour  <= bg_fn(BgAddr);
    SprColour <= spr_mem[SprAddr];
  end

  // Per-frame plot monitor; fcyc is (frame cycle - 1) at this sample point.
  int fcyc = 0, bg_plots = 0, spr_plots = 0, bad_pos = 0, done_cnt = 0;
  always_ff @(negedge Clock) begin
    if (!Busy) fcyc <= 0;
    else       fcyc <= fcyc + 1;
    if (Busy && fcyc == 0) begin
      bg_plots  <= 0;
      spr_plots <= 0;
      bad_pos   <= 0;
    end else if (plot) begin
      if (fcyc < 19201) bg_plots <= bg_plots + 1;
      else begin
        spr_plots <= spr_plots + 1;
        if (VGA_X > 8'd159 || VGA_Y > 7'd119) bad_pos <= bad_pos + 1;
      end
    end
    if (Done) done_cnt <= done_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  logic [14:0] exp_addr;
  int n;
  int s_off;

  initial begin
    Resetn = 1'b0; Tick = 1'b0; s_tick = 1'b0;
    SprX = 8'd10; SprY = 7'd10;
    for (int i = 0; i < 256; i++) spr_mem[i] = 3'b000;
    spr_mem[0] = 3'b100;
    repeat (3) step();

    check_val("rst_busy",   Busy, 0);
    check_val("rst_plot",   plot, 0);
    check_val("rst_done",   Done, 0);
    check_val("rst_offset", Offset, 0);
    check_val("rst_vga_x",  VGA_X, 0);
    check_val("rst_vga_y",  VGA_Y, 0);
    Resetn = 1'b1;
    step();

    // Offset wrap on the 4x5 instance: frames 1..6 give 1,2,3,4,0,1.
    for (int f = 1; f <= 6; f++) begin
      s_tick = 1'b1;
      step();
      s_tick = 1'b0;
      s_off = f % 5;
      check_val($sformatf("wrap_offset_f%0d", f), s_offset, s_off);
      check_val($sformatf("wrap_addr_f%0d", f), s_bg_addr,
                (s_off == 0) ? 0 : (5 - s_off) * 256);
      n = 0;
      while (s_busy && n < 40) begin step(); n++; end
      check_val($sformatf("wrap_len_f%0d", f), n, 25);
    end
    step();

    // Frame 1: Tick at cycle 0.
    Tick = 1'b1;
    step();
    Tick = 1'b0;
    check_val("f1_offset", Offset, 1);
    check_val("f1_busy",   Busy, 1);
    check_val("f1_bgaddr", BgAddr, {7'd119, 8'd0});
    check_val("f1_plot_c1", plot, 0);
    step();
    exp_addr = {7'd119, 8'd0};
    check_val("f1_plot_c2", plot, 1);
    check_val("f1_x_c2", VGA_X, 0);
    check_val("f1_y_c2", VGA_Y, 0);
    check_val("f1_colour_c2", VGA_COLOUR, bg_fn(exp_addr));
    n = 2;
    while (!Done && n < 20000) begin
      step(); n++;
      Tick = (n == 100 || n == 200);
      if (n == 300) begin SprX = 8'd150; SprY = 7'd110; end
    end
    Tick = 1'b0;
    check_val("f1_done_cycle", n, 19457);
    step();
    check_val("f1_gap_busy", Busy, 0);
    check_val("f1_bg_plots", bg_plots, 19200);
    check_val("f1_spr_plots", spr_plots, EXP_SPR_F1);
    step();
    check_val("f2_start_busy", Busy, 1);
    check_val("f2_offset", Offset, 2);

    // Frame 2: pending frame with clipped sprite at (150,110).
    n = 1;
    while (!Done && n < 20000) begin step(); n++; end
    check_val("f2_done_cycle", n, 19457);
    step();
    check_val("f2_bg_plots", bg_plots, 19200);
    check_val("f2_spr_plots", spr_plots, EXP_SPR_F2);
    check_val("f2_clip_bad", bad_pos, 0);
    repeat (5) step();
    check_val("no_third_busy", Busy, 0);
    check_val("no_third_offset", Offset, 2);

    // Reset in the middle of frame 3.
    Tick = 1'b1;
    step();
    Tick = 1'b0;
    n = 1;
    while (n < 5000) begin step(); n++; end
    Resetn = 1'b0;
    step();
    check_val("mid_rst_plot", plot, 0);
    check_val("mid_rst_busy", Busy, 0);
    check_val("mid_rst_offset", Offset, 0);
    check_val("mid_rst_done", Done, 0);
    Resetn = 1'b1;
    repeat (3) step();
    check_val("mid_rst_done_cnt", done_cnt, 2);
    Tick = 1'b1;
    step();
    Tick = 1'b0;
    check_val("restart_offset", Offset, 1);
    check_val("restart_bgaddr", BgAddr, {7'd119, 8'd0});
    step();
    check_val("restart_plot", plot, 1);
    check_val("restart_x", VGA_X, 0);
    check_val("restart_y", VGA_Y, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
